// File: rtl/alu_ctrl_sequencer.sv
// Registered ALU control decode with a one-entry valid/ready output stage.
// MULT/DIV hold the result back for a programmable number of cycles and raise busy meanwhile.
module alu_ctrl_sequencer #(
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] ALUOP,
  input  logic [FUNCT_W-1:0] FunctCode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ALUOPcode,
  output logic               illegal,
  output logic               multicycle,
  output logic               busy
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StCount} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CTRL_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_multi;
  logic [CNT_W-1:0]  dec_load;
  logic              accept;

  always_comb begin
    dec_code    = '1;
    dec_illegal = 1'b1;
    dec_multi   = 1'b0;
    dec_load    = '0;
    case (ALUOP)
      ALUOP_W'(3'b100): begin dec_code = CTRL_W'(4'b0010); dec_illegal = 1'b0; end
      ALUOP_W'(3'b111): begin dec_code = CTRL_W'(4'b0110); dec_illegal = 1'b0; end
      ALUOP_W'(3'b101): begin dec_code = CTRL_W'(4'b0000); dec_illegal = 1'b0; end
      ALUOP_W'(3'b110): begin dec_code = CTRL_W'(4'b0001); dec_illegal = 1'b0; end
      ALUOP_W'(3'b010): begin
        dec_illegal = 1'b0;
        case (FunctCode)
          FUNCT_W'(6'b100000): dec_code = CTRL_W'(4'b0010);
          FUNCT_W'(6'b100010): dec_code = CTRL_W'(4'b0110);
          FUNCT_W'(6'b100100): dec_code = CTRL_W'(4'b0000);
          FUNCT_W'(6'b100101): dec_code = CTRL_W'(4'b0001);
          FUNCT_W'(6'b101010): dec_code = CTRL_W'(4'b0111);
          FUNCT_W'(6'b100111): dec_code = CTRL_W'(4'b1100);
          FUNCT_W'(6'b011000): begin
            dec_code  = CTRL_W'(4'b1000);
            dec_multi = 1'b1;
            dec_load  = MUL_LOAD;
          end
          FUNCT_W'(6'b011010): begin
            dec_code  = CTRL_W'(4'b1001);
            dec_multi = 1'b1;
            dec_load  = DIV_LOAD;
          end
          default: begin
            dec_code    = '1;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_code    = '1;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // HOLD passes out_ready straight through so a consumed result never costs a bubble.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StIdle:  in_ready = 1'b1;
      StHold:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign busy   = (state_q == StCount);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      ALUOPcode  <= '0;
      illegal    <= 1'b0;
      multicycle <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            ALUOPcode  <= dec_code;
            illegal    <= dec_illegal;
            multicycle <= dec_multi;
            // A load of zero means a one-cycle MULT/DIV: skip straight to HOLD.
            if (dec_multi && (dec_load != '0)) begin
              state_q   <= StCount;
              cnt_q     <= dec_load;
              out_valid <= 1'b0;
            end else begin
              state_q   <= StHold;
              out_valid <= 1'b1;
            end
          end else if ((state_q == StHold) && out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        StCount: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_q   <= StHold;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed scenario tasks plus a randomized stream checked against a transaction-timing model.
module tb_alu_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] ALUOP = 3'b000;
  logic [5:0] FunctCode = 6'b000000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] ALUOPcode;
  logic       illegal;
  logic       multicycle;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  alu_ctrl_sequencer #(
    .ALUOP_W   (3),
    .FUNCT_W   (6),
    .CTRL_W    (4),
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOP     (ALUOP),
    .FunctCode (FunctCode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOPcode (ALUOPcode),
    .illegal   (illegal),
    .multicycle(multicycle),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101, F_SLT = 6'b101010, F_NOR = 6'b100111;
  localparam logic [5:0] F_MUL = 6'b011000, F_DIV = 6'b011010;

  // {out_valid, ALUOPcode, illegal, multicycle, busy, in_ready}
  function automatic logic [8:0] obs();
    return {out_valid, ALUOPcode, illegal, multicycle, busy, in_ready};
  endfunction

  task automatic drive(input logic v, input logic [2:0] a, input logic [5:0] f, input logic r);
    @(negedge clk);
    in_valid  = v;
    ALUOP     = a;
    FunctCode = f;
    out_ready = r;
    #1;
  endtask

  // Spec-level decode: control code, illegal flag and latency in cycles.
  task automatic ref_decode(input logic [2:0] a, input logic [5:0] f,
                            output logic [3:0] code, output logic ill, output int n);
    code = 4'b1111; ill = 1'b1; n = 1;
    if (a == 3'b100) begin code = 4'b0010; ill = 1'b0; end
    else if (a == 3'b111) begin code = 4'b0110; ill = 1'b0; end
    else if (a == 3'b101) begin code = 4'b0000; ill = 1'b0; end
    else if (a == 3'b110) begin code = 4'b0001; ill = 1'b0; end
    else if (a == 3'b010) begin
      ill = 1'b0;
      if (f == F_ADD) code = 4'b0010;
      else if (f == F_SUB) code = 4'b0110;
      else if (f == F_AND) code = 4'b0000;
      else if (f == F_OR)  code = 4'b0001;
      else if (f == F_SLT) code = 4'b0111;
      else if (f == F_NOR) code = 4'b1100;
      else if (f == F_MUL) begin code = 4'b1000; n = MUL_N; end
      else if (f == F_DIV) begin code = 4'b1001; n = DIV_N; end
      else begin code = 4'b1111; ill = 1'b1; end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; ALUOP = 3'b100; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (obs() !== 9'b0_0000_0001)
      begin errors++; $display("FAIL reset_state: got %b want %b", obs(), 9'b0_0000_0001); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn [4];
    logic [3:0] ex [4];
    fn = '{F_ADD, F_SUB, F_SLT, F_OR};
    ex = '{4'b0010, 4'b0010, 4'b0110, 4'b0111};
    drive(1'b1, 3'b100, 6'd0, 1'b1);
    vectors++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      begin errors++; $display("FAIL b2b_idle: got %b want 001", {out_valid, busy, in_ready}); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b010, fn[i], 1'b1);
      vectors++;
      if (obs() !== {1'b1, ex[i], 4'b0001}) begin
        errors++;
        $display("FAIL b2b_%0d: got %b want %b", i, obs(), {1'b1, ex[i], 4'b0001});
      end
    end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b0001, 4'b0001})
      begin errors++; $display("FAIL b2b_last: got %b want %b", obs(), {1'b1, 4'b0001, 4'b0001}); end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      begin errors++; $display("FAIL b2b_drain: got %b want 001", {out_valid, busy, in_ready}); end
  endtask

  task automatic test_mult();
    drive(1'b1, 3'b010, F_MUL, 1'b1);
    vectors++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      begin errors++; $display("FAIL mul_accept: got %b want 001", {out_valid, busy, in_ready}); end
    for (int i = 1; i < MUL_N; i++) begin
      drive(1'b1, 3'b100, 6'd0, 1'b1);
      vectors++;
      if ({out_valid, busy, in_ready} !== 3'b010) begin
        errors++;
        $display("FAIL mul_busy_%0d: got %b want 010", i, {out_valid, busy, in_ready});
      end
    end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b1000, 4'b0101})
      begin errors++; $display("FAIL mul_result: got %b want %b", obs(), {1'b1, 4'b1000, 4'b0101}); end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      begin errors++; $display("FAIL mul_drain: got %b want 001", {out_valid, busy, in_ready}); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 3'b010, F_SUB, 1'b1);
    drive(1'b1, 3'b010, F_OR, 1'b0);
    vectors++;
    if (obs() !== {1'b1, 4'b0110, 4'b0000})
      begin errors++; $display("FAIL bp_stall1: got %b want %b", obs(), {1'b1, 4'b0110, 4'b0000}); end
    drive(1'b1, 3'b010, F_AND, 1'b0);
    vectors++;
    if (obs() !== {1'b1, 4'b0110, 4'b0000})
      begin errors++; $display("FAIL bp_stall2: got %b want %b", obs(), {1'b1, 4'b0110, 4'b0000}); end
    drive(1'b1, 3'b010, F_AND, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b0110, 4'b0001})
      begin errors++; $display("FAIL bp_release: got %b want %b", obs(), {1'b1, 4'b0110, 4'b0001}); end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b0000, 4'b0001})
      begin errors++; $display("FAIL bp_next: got %b want %b", obs(), {1'b1, 4'b0000, 4'b0001}); end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b010, 6'b111111, 1'b1);
    drive(1'b1, 3'b011, 6'b000000, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b1111, 4'b1001})
      begin errors++; $display("FAIL ill_funct: got %b want %b", obs(), {1'b1, 4'b1111, 4'b1001}); end
    drive(1'b1, 3'b101, 6'b000000, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b1111, 4'b1001})
      begin errors++; $display("FAIL ill_aluop: got %b want %b", obs(), {1'b1, 4'b1111, 4'b1001}); end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b0000, 4'b0001})
      begin errors++; $display("FAIL ill_clear: got %b want %b", obs(), {1'b1, 4'b0000, 4'b0001}); end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
  endtask

  task automatic test_reset_mid_div();
    drive(1'b1, 3'b010, F_DIV, 1'b1);
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if ({out_valid, busy, in_ready} !== 3'b010)
      begin errors++; $display("FAIL div_busy: got %b want 010", {out_valid, busy, in_ready}); end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; ALUOP = 3'b100; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (obs() !== 9'b0_0000_0001)
      begin errors++; $display("FAIL div_reset: got %b want %b", obs(), 9'b0_0000_0001); end
    drive(1'b1, 3'b010, F_ADD, 1'b1);
    drive(1'b0, 3'b000, 6'd0, 1'b1);
    vectors++;
    if (obs() !== {1'b1, 4'b0010, 4'b0001})
      begin errors++; $display("FAIL div_after_add: got %b want %b", obs(), {1'b1, 4'b0010, 4'b0001}); end
    drive(1'b0, 3'b000, 6'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0] ta [10];
    logic [5:0] tf [10];
    bit         pend;
    int         valid_at, cyc, n, sel;
    logic [3:0] m_code, c;
    logic       m_ill, m_mc, il, iv, ordy, exp_ov, exp_busy, exp_ir;
    logic [2:0] a;
    logic [5:0] f;
    ta = '{3'b100, 3'b111, 3'b101, 3'b110, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    tf = '{6'd0, 6'd0, 6'd0, 6'd0, F_ADD, F_SLT, F_NOR, F_MUL, F_DIV, F_AND};
    apply_reset();
    pend = 1'b0; valid_at = 0; cyc = 0;
    m_code = '0; m_ill = 1'b0; m_mc = 1'b0;
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 11);
      if (sel < 10) begin a = ta[sel]; f = tf[sel]; end
      else if (sel == 10) begin a = 3'($urandom); f = 6'($urandom); end
      else begin a = 3'b010; f = 6'($urandom); end
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      drive(iv, a, f, ordy);
      exp_ov   = pend && (cyc >= valid_at);
      exp_busy = pend && (cyc < valid_at);
      exp_ir   = !pend || (exp_ov && ordy);
      vectors++;
      if ({out_valid, busy, in_ready} !== {exp_ov, exp_busy, exp_ir}) begin
        errors++;
        $display("FAIL rnd_hs cyc %0d: got %b want %b", k, {out_valid, busy, in_ready},
                 {exp_ov, exp_busy, exp_ir});
      end
      if (exp_ov) begin
        vectors++;
        if ({ALUOPcode, illegal, multicycle} !== {m_code, m_ill, m_mc}) begin
          errors++;
          $display("FAIL rnd_data cyc %0d: got %b want %b", k, {ALUOPcode, illegal, multicycle},
                   {m_code, m_ill, m_mc});
        end
      end
      if (exp_ov && ordy) pend = 1'b0;
      if (iv && exp_ir) begin
        ref_decode(a, f, c, il, n);
        pend = 1'b1; valid_at = cyc + n;
        m_code = c; m_ill = il; m_mc = (n > 1);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mult();
    test_backpressure();
    test_illegal();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
